// File: rtl/rs232out.sv
// rs232out: 8-entry FIFO feeding an 8N1 LSB-first UART transmitter, one clock from write to start bit.
// Backpressure: busy while the FIFO holds 8 bytes; writes offered then are dropped.
module rs232out #(
    parameter int bps       = 57_600,
    parameter int frequency = 25_000_000,
    parameter int period    = frequency / bps - 1
) (
    input  logic       clk25MHz,
    input  logic       reset,
    input  logic       transmit,
    input  logic [7:0] transmit_data,
    output logic       busy,
    output logic       idle,
    output logic       serial_out
);
    localparam int            BW       = (period < 1) ? 1 : $clog2(period + 1);
    localparam logic [BW-1:0] PERIOD_V = BW'(period);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        r_state;
    logic [7:0]    r_mem [8];
    logic [2:0]    r_wp;
    logic [2:0]    r_rp;
    logic [3:0]    r_count;
    logic [9:0]    r_frame;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic          r_serial;
    logic          r_busy;
    logic          r_idle;

    logic       w_empty;
    logic       w_full;
    logic       w_frame_end;
    logic       w_pop;
    logic       w_push;
    logic       w_next_idle;
    logic [3:0] w_count_nxt;

    assign w_empty     = (r_count == 4'd0);
    assign w_full      = (r_count == 4'd8);
    assign w_frame_end = (r_state == SEND) && (r_baud == '0) && (r_bit == 4'd0);
    // A pop at the stop-bit end chains the next frame with no gap cycle.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    // Fullness uses the pre-edge count, so a same-edge pop never rescues a write.
    assign w_push      = transmit && !w_full;
    assign w_next_idle = !w_pop && ((r_state == IDLE) || w_frame_end);
    assign w_count_nxt = r_count + {3'd0, w_push} - {3'd0, w_pop};

    always_ff @(posedge clk25MHz) begin
        if (w_push) begin
            r_mem[r_wp] <= transmit_data;
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            r_state  <= IDLE;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_frame  <= '1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_serial <= 1'b1;
            r_busy   <= 1'b0;
            r_idle   <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_busy  <= (w_count_nxt == 4'd8);
            r_idle  <= w_next_idle && (w_count_nxt == 4'd0);
            if (w_push) begin
                r_wp <= r_wp + 3'd1;
            end
            if (w_pop) begin
                r_state  <= SEND;
                r_rp     <= r_rp + 3'd1;
                r_frame  <= {1'b1, r_mem[r_rp], 1'b0};
                r_serial <= 1'b0;
                r_baud   <= PERIOD_V;
                r_bit    <= 4'd9;
            end else if (r_state == SEND) begin
                if (r_baud != '0) begin
                    r_baud <= r_baud - BW'(1);
                end else if (r_bit != 4'd0) begin
                    r_frame  <= {1'b1, r_frame[9:1]};
                    r_serial <= r_frame[1];
                    r_baud   <= PERIOD_V;
                    r_bit    <= r_bit - 4'd1;
                end else begin
                    r_state  <= IDLE;
                    r_serial <= 1'b1;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign idle       = r_idle;
    assign serial_out = r_serial;

endmodule

// File: tb/tb_rs232out.sv
// Bench for rs232out: queue/timeline reference model, per-cycle compare, bench UART receiver, literal checks.
module tb_rs232out;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       transmit;
    logic [7:0] transmit_data;
    logic       busy;
    logic       idle;
    logic       serial_out;
    logic       transmit_d;
    logic [7:0] data_d;
    logic       busy_d;
    logic       idle_d;
    logic       so_d;

    always #5 clk = ~clk;

    rs232out #(.bps(2_500_000)) dut (
        .clk25MHz(clk), .reset(reset), .transmit(transmit), .transmit_data(transmit_data),
        .busy(busy), .idle(idle), .serial_out(serial_out)
    );

    rs232out dut_def (
        .clk25MHz(clk), .reset(reset), .transmit(transmit_d), .transmit_data(data_d),
        .busy(busy_d), .idle(idle_d), .serial_out(so_d)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: byte queue plus the edge number at which the current frame began.
    logic [7:0] mq[$];
    logic [7:0] popped[$];
    logic [7:0] m_tmp;
    logic [9:0] m_frame = '1;
    bit         m_act = 0;
    int         m_s = 0;
    int         m_pre;
    bit         m_end;
    bit         m_pop;
    logic       exp_serial = 1'b1;
    logic       exp_busy = 1'b0;
    logic       exp_idle = 1'b1;
    bit         rst_seen = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_seen = reset;
        if (reset) begin
            mq.delete();
            m_act = 0;
        end else begin
            m_pre = mq.size();
            m_end = m_act && (cyc - m_s == 10 * CPB);
            m_pop = (!m_act || m_end) && (m_pre > 0);
            if (m_pop) begin
                m_tmp = mq.pop_front();
                m_frame = {1'b1, m_tmp, 1'b0};
                popped.push_back(m_tmp);
                m_s = cyc;
                m_act = 1;
            end else if (m_end) begin
                m_act = 0;
            end
            if (transmit && m_pre < 8) mq.push_back(transmit_data);
        end
        exp_serial = m_act ? m_frame[(cyc - m_s) / CPB] : 1'b1;
        exp_busy   = (mq.size() == 8);
        exp_idle   = !m_act && (mq.size() == 0);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("serial_out", 32'(serial_out), 32'(exp_serial));
            check("busy", 32'(busy), 32'(exp_busy));
            check("idle", 32'(idle), 32'(exp_idle));
        end
    end

    // Bench receiver: mid-bit sampling of the fast DUT's line.
    logic [7:0] rx_got[$];
    logic [7:0] rx_exp[$];
    int         rx_starts[$];
    bit         rx_on = 0;
    int         rx_t = 0;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_sh = '0;

    always @(negedge clk) begin
        if (rst_seen) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (serial_out === 1'b0 && rx_prev === 1'b1) begin
                rx_on = 1;
                rx_t = 0;
                rx_starts.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t >= 15 && rx_t <= 85 && rx_t % CPB == 5) rx_sh = {serial_out, rx_sh[7:1]};
            if (rx_t == 95) begin
                rx_got.push_back(rx_sh);
                rx_on = 0;
            end
        end
        rx_prev = serial_out;
    end

    task automatic wr(input logic [7:0] b);
        transmit = 1'b1;
        transmit_data = b;
        @(negedge clk);
        transmit = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n;
        n = 0;
        while (idle !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(idle), 32'(1));
    endtask

    task automatic check_rx(input string nm);
        check({nm, "_count"}, 32'(rx_got.size()), 32'(rx_exp.size()));
        for (int i = 0; i < rx_exp.size() && i < rx_got.size(); i++)
            check(nm, 32'(rx_got[i]), 32'(rx_exp[i]));
    endtask

    int         e0;
    int         s;
    int         n;
    logic [9:0] lit55;
    logic [9:0] lit41;

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        transmit = 1'b0;
        transmit_data = '0;
        transmit_d = 1'b0;
        data_d = '0;
        lit55 = 10'b10_1010_1010;
        lit41 = 10'b10_1000_0010;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_serial", 32'(serial_out), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_idle", 32'(idle), 32'(1));

        // Single byte 0x55
        rx_got.delete();
        wr(8'h55);
        e0 = cyc;
        s = e0 + 1;
        check("idle_drop", 32'(idle), 32'(0));
        for (int i = 0; i < 10; i++) begin
            wait_cyc(s + CPB * i + 5);
            check("b55_bit", 32'(serial_out), 32'(lit55[i]));
        end
        wait_cyc(s + 99);
        check("b55_idle_early", 32'(idle), 32'(0));
        wait_cyc(s + 100);
        check("b55_idle_at100", 32'(idle), 32'(1));
        rx_exp = '{8'h55};
        check_rx("rx_55");

        // Back-to-back
        rx_got.delete();
        rx_starts.delete();
        wr(8'hA3);
        wr(8'h0F);
        wait_idle(400, "b2b_drain");
        rx_exp = '{8'hA3, 8'h0F};
        check_rx("rx_b2b");
        check("b2b_gap", 32'((rx_starts.size() >= 2) ? rx_starts[1] - rx_starts[0] : -1), 32'(100));

        // FIFO full and drop
        rx_got.delete();
        wr(8'h00);
        e0 = cyc;
        for (int i = 1; i < 10; i++) wr(8'(i));
        check("full_busy", 32'(busy), 32'(1));
        wait_cyc(e0 + 100);
        check("full_busy_held", 32'(busy), 32'(1));
        wait_cyc(e0 + 101);
        check("full_busy_clear", 32'(busy), 32'(0));
        wait_idle(1200, "full_drain");
        rx_exp.delete();
        for (int i = 0; i < 9; i++) rx_exp.push_back(8'(i));
        check_rx("rx_full");

        // Push on the stop-bit-end edge with 3 queued
        rx_got.delete();
        wr(8'h31);
        e0 = cyc;
        wr(8'h32);
        wr(8'h33);
        wr(8'h34);
        wait_cyc(e0 + 100);
        wr(8'h35);
        wait_idle(800, "pp3_drain");
        rx_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        check_rx("rx_pp3");

        // Push on the stop-bit-end edge while full
        rx_got.delete();
        wr(8'h40);
        e0 = cyc;
        for (int i = 1; i < 9; i++) wr(8'h40 + 8'(i));
        wait_cyc(e0 + 100);
        check("pp8_busy", 32'(busy), 32'(1));
        wr(8'h4F);
        wait_idle(1200, "pp8_drain");
        rx_exp.delete();
        for (int i = 0; i < 9; i++) rx_exp.push_back(8'h40 + 8'(i));
        check_rx("rx_pp8");

        // Reset during d3 of 0xFF with two bytes queued
        rx_got.delete();
        wr(8'hFF);
        e0 = cyc;
        wr(8'h11);
        wr(8'h22);
        s = e0 + 1;
        wait_cyc(s + 44);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_serial", 32'(serial_out), 32'(1));
        check("mrst_idle", 32'(idle), 32'(1));
        check("mrst_busy", 32'(busy), 32'(0));
        repeat (300) @(negedge clk);
        check("mrst_quiet", 32'(serial_out), 32'(1));
        check("mrst_no_rx", 32'(rx_got.size()), 32'(0));

        // Randomized traffic
        rx_got.delete();
        popped.delete();
        for (int seg = 0; seg < 30; seg++) begin
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(1, 10);
                repeat (n) wr(8'($urandom));
            end else begin
                n = $urandom_range(0, 300);
                repeat (n) begin
                    transmit = ($urandom_range(0, 59) == 0);
                    transmit_data = 8'($urandom);
                    @(negedge clk);
                end
                transmit = 1'b0;
            end
        end
        wait_idle(1200, "rand_drain");
        rx_exp = popped;
        check_rx("rx_rand");

        // Default parameters: 434 clocks per bit
        transmit_d = 1'b1;
        data_d = 8'h41;
        @(negedge clk);
        transmit_d = 1'b0;
        s = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(s + 434 * i + 217);
            check("def_bit", 32'(so_d), 32'(lit41[i]));
            if (i == 0) begin
                wait_cyc(s + 433);
                check("def_start_end", 32'(so_d), 32'(0));
                wait_cyc(s + 434);
                check("def_d0_begin", 32'(so_d), 32'(1));
            end
            if (i == 8) begin
                wait_cyc(s + 3905);
                check("def_d7_end", 32'(so_d), 32'(0));
                wait_cyc(s + 3906);
                check("def_stop_begin", 32'(so_d), 32'(1));
            end
        end
        wait_cyc(s + 4339);
        check("def_idle_early", 32'(idle_d), 32'(0));
        wait_cyc(s + 4340);
        check("def_idle_frame", 32'(idle_d), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
